// File: rtl/lsu_wb_master.sv
// lsu_wb_master
//   Bridges a simple load/store request port onto a single-beat Wishbone
//   master. Each access goes IDLE -> BUS -> RESP. Store data has its unused
//   lanes zeroed, load data is sign- or zero-extended, and an access that sees
//   no ack within TIMEOUT bus cycles completes with rsp_err set.
//
// Ports
//   iClk, iRst            clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we                1 = store, 0 = load
//   req_addr              byte address, passed through unaligned
//   req_width             00 byte, 01 half, 1x word
//   req_unsigned          zero-extend loads when set
//   req_wdata             store data
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata             extended load data (0 for stores and timeouts)
//   rsp_err               timeout flag, qualified by rsp_valid
//   wb_*                  Wishbone master signals, all registered
module lsu_wb_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_width,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_addr,
  output logic [1:0]  wb_width,
  output logic [31:0] wb_data_write,
  input  logic [31:0] wb_data_read,
  input  logic        wb_ack
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // TIMEOUT-1 is the largest value the counter ever holds.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             unsigned_q;

  // Keep only the lanes the access width uses.
  function automatic logic [31:0] lane_mask(input logic [1:0] w, input logic [31:0] d);
    case (w)
      2'b00:   return {24'd0, d[7:0]};
      2'b01:   return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Sign- or zero-extend the low lanes of the read data.
  function automatic logic [31:0] load_extend(input logic [1:0] w, input logic uns,
                                              input logic [31:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] s;
    b = d[7:0];
    h = d[15:0];
    s = '0;
    case (w)
      2'b00: begin
        s = b;
        return uns ? {24'd0, d[7:0]} : s;
      end
      2'b01: begin
        s = h;
        return uns ? {16'd0, d[15:0]} : s;
      end
      default: return d;
    endcase
  endfunction

  // Reset is folded in so ready stays low for the whole reset pulse.
  assign req_ready = (state == IDLE) && !iRst;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state         <= IDLE;
      cnt           <= '0;
      unsigned_q    <= 1'b0;
      wb_cyc        <= 1'b0;
      wb_stb        <= 1'b0;
      wb_we         <= 1'b0;
      wb_addr       <= '0;
      wb_width      <= '0;
      wb_data_write <= '0;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (req_valid) begin
            wb_cyc        <= 1'b1;
            wb_stb        <= 1'b1;
            wb_we         <= req_we;
            wb_addr       <= req_addr;
            wb_width      <= req_width;
            wb_data_write <= lane_mask(req_width, req_wdata);
            unsigned_q    <= req_unsigned;
            cnt           <= '0;
            state         <= BUS;
          end
        end
        BUS: begin
          // Ack is tested first so it wins over a same-edge timeout.
          if (wb_ack) begin
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= wb_we ? 32'd0 : load_extend(wb_width, unsigned_q, wb_data_read);
            state     <= RESP;
          end else if (cnt == CNT_LAST) begin
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'd0;
            state     <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_wb_master.sv
module tb_lsu_wb_master;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_width;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        wb_cyc, wb_stb, wb_we, wb_ack;
  logic [31:0] wb_addr, wb_data_write, wb_data_read;
  logic [1:0]  wb_width;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 iClk = ~iClk;

  lsu_wb_master #(.TIMEOUT(4)) dut (
    .iClk(iClk), .iRst(iRst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_width(req_width), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_width(wb_width), .wb_data_write(wb_data_write),
    .wb_data_read(wb_data_read), .wb_ack(wb_ack)
  );

  // RAM slave: little-endian byte RAM, ack after ack_wait stalled cycles.
  logic [7:0] ram [256] = '{default: 8'h00};
  logic [7:0] model_mem [256] = '{default: 8'h00};
  logic       ack_en = 1'b1;
  int         ack_wait = 0;
  int         wait_cnt = 0;
  logic [7:0] sa;

  assign sa = wb_addr[7:0];
  assign wb_ack = wb_cyc && wb_stb && ack_en && (wait_cnt >= ack_wait);
  assign wb_data_read = {ram[sa + 8'd3], ram[sa + 8'd2], ram[sa + 8'd1], ram[sa]};

  always @(posedge iClk) begin
    if (wb_cyc && wb_stb && !wb_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (wb_cyc && wb_stb && wb_ack && wb_we) begin
      ram[sa] <= wb_data_write[7:0];
      if (wb_width != 2'b00) ram[sa + 8'd1] <= wb_data_write[15:8];
      if (wb_width[1]) begin
        ram[sa + 8'd2] <= wb_data_write[23:16];
        ram[sa + 8'd3] <= wb_data_write[31:24];
      end
    end
  end

  // Reference model: bytes touched, value read back, extension by arithmetic.
  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] w, input logic uns);
    longint v = 0;
    int n = nbytes(w);
    for (int k = 0; k < n; k++) v += longint'(model_mem[(a + k) & 255]) << (8 * k);
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] w, input logic [31:0] d);
    longint m = (longint'(1) << (8 * nbytes(w))) - 1;
    return 32'(longint'(d) & m);
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    for (int k = 0; k < nbytes(w); k++) model_mem[(a + k) & 255] = d[8*k +: 8];
  endtask

  // Issues one request and watches it to completion (no comparisons here).
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [1:0] width,
                           input logic uns, input logic [31:0] wdata,
                           output logic ok, output int lat, output int stb_cnt,
                           output logic [31:0] rdata, output logic err,
                           output logic [31:0] wdw, output logic single);
    int guard = 0;
    ok = 0; lat = 0; stb_cnt = 0; rdata = '0; err = 0; wdw = '0; single = 0;
    @(negedge iClk);
    req_we = we; req_addr = addr; req_width = width; req_unsigned = uns;
    req_wdata = wdata; req_valid = 1'b1;
    while (!req_ready && guard < 50) begin
      @(negedge iClk);
      guard++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge iClk);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge iClk);
      if (wb_stb) begin
        stb_cnt++;
        wdw = wb_data_write;
      end
      if (rsp_valid) begin
        ok = 1; lat = i; rdata = rsp_rdata; err = rsp_err;
        break;
      end
    end
    if (ok) begin
      @(negedge iClk);
      single = !rsp_valid;
    end
    if (ok && we && !err) model_store(addr, width, wdata);
  endtask

  task automatic test_reset;
    iRst = 1'b1; req_valid = 1'b0; req_we = 0; req_addr = 0; req_width = 0;
    req_unsigned = 0; req_wdata = 0;
    #3;
    n_checks++;
    if ({wb_cyc, wb_stb, wb_we, wb_addr, wb_width, wb_data_write, rsp_valid, rsp_err, rsp_rdata} !== '0)
      $display("FAIL reset_outputs: got cyc=%b stb=%b rv=%b rdata=%h, want all 0", wb_cyc, wb_stb, rsp_valid, rsp_rdata);
    else n_pass++;
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", req_ready);
    else n_pass++;
    @(negedge iClk); @(negedge iClk);
    iRst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", req_ready);
    else n_pass++;
  endtask

  task automatic test_word;
    logic ok, err, single; int lat, sc; logic [31:0] rd, wdw;
    ack_wait = 0;
    do_access(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, ok, lat, sc, rd, err, wdw, single);
    n_checks++;
    if (!ok || rd !== 32'h0 || err !== 1'b0 || wdw !== 32'hDEADBEEF)
      $display("FAIL word_store: ok=%b rdata=%h err=%b wdata=%h, want 1/00000000/0/deadbeef", ok, rd, err, wdw);
    else n_pass++;
    do_access(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, ok, lat, sc, rd, err, wdw, single);
    n_checks++;
    if (!ok || rd !== 32'hDEADBEEF || err !== 1'b0)
      $display("FAIL word_load: ok=%b rdata=%h err=%b, want deadbeef err 0", ok, rd, err);
    else n_pass++;
    n_checks++;
    if (lat !== 2 || single !== 1'b1)
      $display("FAIL word_latency: got lat=%0d single=%b, want 2 and 1", lat, single);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic seen = 0;
    ack_en = 1'b0;
    @(negedge iClk);
    req_we = 0; req_addr = 32'h10; req_width = 2'b10; req_unsigned = 0; req_valid = 1'b1;
    @(posedge iClk);
    #1 req_valid = 1'b0;
    @(negedge iClk);
    n_checks++;
    if (wb_stb !== 1'b1 || wb_cyc !== 1'b1) $display("FAIL mid_stb_before: got stb=%b cyc=%b want 1/1", wb_stb, wb_cyc);
    else n_pass++;
    #1 iRst = 1'b1;
    #1;
    n_checks++;
    if (wb_stb !== 1'b0 || wb_cyc !== 1'b0 || req_ready !== 1'b0 || rsp_rdata !== 32'h0)
      $display("FAIL mid_async_drop: got stb=%b cyc=%b ready=%b rdata=%h want 0/0/0/0", wb_stb, wb_cyc, req_ready, rsp_rdata);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      if (rsp_valid) seen = 1;
    end
    iRst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL mid_ready_after: got %b want 1", req_ready);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge iClk);
      if (rsp_valid) seen = 1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL mid_no_rsp: got rsp_valid seen=%b want 0", seen);
    else n_pass++;
    ack_en = 1'b1;
  endtask

  task automatic test_byte_sign;
    logic ok, err, single; int lat, sc; logic [31:0] rd, wdw;
    do_access(1'b1, 32'h20, 2'b00, 1'b0, 32'hABCDEF80, ok, lat, sc, rd, err, wdw, single);
    n_checks++;
    if (!ok || wdw !== 32'h00000080) $display("FAIL byte_store_mask: got %h want 00000080", wdw);
    else n_pass++;
    do_access(1'b0, 32'h20, 2'b00, 1'b0, 32'h0, ok, lat, sc, rd, err, wdw, single);
    n_checks++;
    if (!ok || rd !== 32'hFFFFFF80) $display("FAIL byte_signed: got %h want ffffff80", rd);
    else n_pass++;
    do_access(1'b0, 32'h20, 2'b00, 1'b1, 32'h0, ok, lat, sc, rd, err, wdw, single);
    n_checks++;
    if (!ok || rd !== 32'h00000080) $display("FAIL byte_unsigned: got %h want 00000080", rd);
    else n_pass++;
  endtask

  task automatic test_half;
    logic ok, err, single; int lat, sc; logic [31:0] rd, wdw;
    do_access(1'b1, 32'h30, 2'b01, 1'b0, 32'h12345678, ok, lat, sc, rd, err, wdw, single);
    n_checks++;
    if (!ok || wdw !== 32'h00005678) $display("FAIL half_store_mask: got %h want 00005678", wdw);
    else n_pass++;
    do_access(1'b0, 32'h30, 2'b01, 1'b0, 32'h0, ok, lat, sc, rd, err, wdw, single);
    n_checks++;
    if (!ok || rd !== 32'h00005678) $display("FAIL half_signed: got %h want 00005678", rd);
    else n_pass++;
  endtask

  task automatic test_random;
    logic ok, err, single, we, uns; int lat, sc; logic [31:0] rd, wdw, a, d, exp;
    logic [1:0] w;
    for (int t = 0; t < 40; t++) begin
      we = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
      w = 2'($urandom_range(0, 3)); a = 32'($urandom_range(0, 255));
      d = $urandom; ack_wait = $urandom_range(0, 2);
      exp = we ? 32'h0 : model_load(a, w, uns);
      do_access(we, a, w, uns, d, ok, lat, sc, rd, err, wdw, single);
      n_checks++;
      if (!ok || rd !== exp || err !== 1'b0 || lat !== 2 + ack_wait || single !== 1'b1)
        $display("FAIL rand_%0d: we=%b w=%b a=%h got rdata=%h err=%b lat=%0d single=%b, want %h/0/%0d/1",
                 t, we, w, a, rd, err, lat, single, exp, 2 + ack_wait);
      else n_pass++;
      if (we) begin
        n_checks++;
        if (wdw !== model_wdata(w, d)) $display("FAIL rand_wdata_%0d: got %h want %h", t, wdw, model_wdata(w, d));
        else n_pass++;
      end
    end
    ack_wait = 0;
  endtask

  task automatic test_ack_priority;
    logic ok, err, single; int lat, sc; logic [31:0] rd, wdw;
    ack_wait = 3;
    do_access(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, ok, lat, sc, rd, err, wdw, single);
    n_checks++;
    if (!ok || err !== 1'b0 || rd !== model_load(32'h10, 2'b10, 1'b0) || sc !== 4)
      $display("FAIL ack_priority: got err=%b rdata=%h stb=%0d, want 0/%h/4", err, rd, model_load(32'h10, 2'b10, 1'b0), sc);
    else n_pass++;
    ack_wait = 0;
  endtask

  task automatic test_timeout;
    logic ok, err, single; int lat, sc; logic [31:0] rd, wdw;
    ack_en = 1'b0;
    do_access(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, ok, lat, sc, rd, err, wdw, single);
    n_checks++;
    if (!ok || sc !== 4 || lat !== 5)
      $display("FAIL timeout_timing: ok=%b stb_cycles=%0d lat=%0d, want 1/4/5", ok, sc, lat);
    else n_pass++;
    n_checks++;
    if (err !== 1'b1 || rd !== 32'h0 || single !== 1'b1)
      $display("FAIL timeout_resp: got err=%b rdata=%h single=%b, want 1/00000000/1", err, rd, single);
    else n_pass++;
    ack_en = 1'b1;
  endtask

  task automatic test_back_to_back;
    int pulses[$]; int acc = 0; logic take; logic [31:0] exp;
    ack_wait = 0;
    exp = model_load(32'h30, 2'b10, 1'b0);
    @(negedge iClk);
    req_we = 0; req_addr = 32'h30; req_width = 2'b10; req_unsigned = 0; req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) begin
        pulses.push_back(c);
        n_checks++;
        if (rsp_rdata !== exp || rsp_err !== 1'b0)
          $display("FAIL b2b_data_%0d: got %h err=%b want %h err 0", c, rsp_rdata, rsp_err, exp);
        else n_pass++;
      end
      take = req_valid && req_ready;
      @(posedge iClk);
      #1;
      if (take) begin
        acc++;
        if (acc == 3) req_valid = 1'b0;
      end
      @(negedge iClk);
    end
    req_valid = 1'b0;
    n_checks++;
    if (pulses.size() !== 3) $display("FAIL b2b_count: got %0d pulses want 3", pulses.size());
    else begin
      n_pass++;
      n_checks++;
      if (pulses[1] - pulses[0] !== 3 || pulses[2] - pulses[1] !== 3)
        $display("FAIL b2b_spacing: got %0d,%0d want 3,3", pulses[1] - pulses[0], pulses[2] - pulses[1]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_word;
    test_reset_mid;
    test_byte_sign;
    test_half;
    test_random;
    test_ack_priority;
    test_timeout;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
